// File: rtl/nn_layer_sequencer.sv
// Control sequencer for a two-layer fully-connected network: streams the input vector and
// per-neuron weights into RAM, drives an external MAC chunk by chunk, then picks the argmax class.
module nn_layer_sequencer #(
  parameter int LANES    = 20,
  parameter int DW       = 8,
  parameter int N_IN     = 1000,
  parameter int N_HID    = 100,
  parameter int N_OUT    = 2,
  parameter int AW       = 16,
  parameter int HID_BASE = 1001,
  parameter int MAC_LAT  = 2,
  localparam int CAT_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  output logic                 act_en,
  output logic                 act_we,
  output logic                 act_wsel,
  output logic [AW-1:0]        act_addr,
  output logic                 wgt_en,
  output logic                 wgt_we,
  output logic [AW-1:0]        wgt_addr,
  output logic                 mac_clear,
  output logic                 mac_acc,
  output logic                 mac_bias,
  input  logic signed [DW-1:0] mac_result,
  output logic                 busy,
  output logic                 done,
  output logic                 cat_valid,
  output logic [CAT_W-1:0]     category
);

  localparam int C0   = (N_IN + LANES - 1) / LANES;
  localparam int C1   = (N_HID + LANES - 1) / LANES;
  localparam int CMAX = (C0 > C1) ? C0 : C1;
  localparam int BW   = $clog2(CMAX + 1) + 1;
  localparam int NMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int NW   = $clog2(NMAX) + 1;
  localparam int WW   = $clog2(MAC_LAT + 1) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IN, S_LOAD_W, S_MAC, S_BIAS, S_WAIT, S_WB, S_ARGMAX, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                 layer;      // 0 hidden layer, 1 output layer
  logic [BW-1:0]        b;          // load beat / MAC chunk counter
  logic [NW-1:0]        n;          // neuron index, reused as argmax index
  logic [WW-1:0]        wcnt;
  logic signed [DW-1:0] best_val;
  logic [CAT_W-1:0]     best_idx;
  logic signed [DW-1:0] result [N_OUT];

  // Load stream: a beat transfers on a cycle where ld_valid && ld_ready; ld_ready depends
  // only on state, and the matching RAM write strobe is asserted in that same cycle.
  logic load_phase, accept;
  assign load_phase = (state == S_LOAD_IN) || (state == S_LOAD_W);
  assign accept     = ld_valid && load_phase;

  logic [BW-1:0]    c_cur;
  logic [AW-1:0]    chunk_addr, bias_addr;
  logic [CAT_W-1:0] out_idx;
  logic             last_in, last_w, last_chunk, wait_done, n_last, am_take;

  assign c_cur      = layer ? BW'(C1) : BW'(C0);
  assign chunk_addr = AW'(b) * AW'(LANES);
  assign bias_addr  = AW'(c_cur) * AW'(LANES);
  assign out_idx    = CAT_W'(n);
  assign last_in    = (b == BW'(C0 - 1));
  assign last_w     = (b == c_cur);
  assign last_chunk = (b == c_cur - 1'b1);
  assign wait_done  = (wcnt == WW'(MAC_LAT - 1));
  assign n_last     = layer ? (n == NW'(N_OUT - 1)) : (n == NW'(N_HID - 1));
  // Strict greater-than keeps the lowest index on ties.
  assign am_take    = (n == '0) || (result[out_idx] > best_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD_IN;
      S_LOAD_IN: if (accept && last_in) state_nxt = S_LOAD_W;
      S_LOAD_W:  if (accept && last_w) state_nxt = S_MAC;
      S_MAC:     if (last_chunk) state_nxt = S_BIAS;
      S_BIAS:    state_nxt = S_WAIT;
      S_WAIT:    if (wait_done) state_nxt = S_WB;
      S_WB:      state_nxt = (layer && n_last) ? S_ARGMAX : S_LOAD_W;
      S_ARGMAX:  if (n_last) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    act_en   = 1'b0;
    act_we   = 1'b0;
    act_wsel = 1'b0;
    act_addr = '0;
    wgt_en   = 1'b0;
    wgt_we   = 1'b0;
    wgt_addr = '0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_LOAD_IN: begin
        ld_ready = 1'b1;
        act_en   = ld_valid;
        act_we   = ld_valid;
        act_addr = chunk_addr;
      end
      S_LOAD_W: begin
        ld_ready = 1'b1;
        wgt_en   = ld_valid;
        wgt_we   = ld_valid;
        wgt_addr = chunk_addr;
      end
      S_MAC: begin
        act_en   = 1'b1;
        wgt_en   = 1'b1;
        act_addr = layer ? AW'(HID_BASE) + chunk_addr : chunk_addr;
        wgt_addr = chunk_addr;
      end
      S_BIAS: begin
        wgt_en   = 1'b1;
        wgt_addr = bias_addr;
      end
      S_WB: begin
        if (!layer) begin
          act_en   = 1'b1;
          act_we   = 1'b1;
          act_wsel = 1'b1;
          act_addr = AW'(HID_BASE) + AW'(n);
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Counters, MAC strobes (one cycle behind the RAM read address) and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer     <= 1'b0;
      b         <= '0;
      n         <= '0;
      wcnt      <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      cat_valid <= 1'b0;
      category  <= '0;
      mac_clear <= 1'b0;
      mac_acc   <= 1'b0;
      mac_bias  <= 1'b0;
      for (int i = 0; i < N_OUT; i++) result[i] <= '0;
    end else begin
      mac_clear <= (state == S_MAC) && (b == '0);
      mac_acc   <= (state == S_MAC);
      mac_bias  <= (state == S_BIAS);
      case (state)
        S_IDLE: begin
          if (start) begin
            cat_valid <= 1'b0;
            layer     <= 1'b0;
            b         <= '0;
            n         <= '0;
          end
        end
        S_LOAD_IN: if (accept) b <= last_in ? '0 : b + 1'b1;
        S_LOAD_W:  if (accept) b <= last_w ? '0 : b + 1'b1;
        S_MAC:     b <= last_chunk ? '0 : b + 1'b1;
        S_BIAS:    wcnt <= '0;
        S_WAIT:    wcnt <= wcnt + 1'b1;
        S_WB: begin
          if (layer) result[out_idx] <= mac_result;
          if (n_last) begin
            n     <= '0;
            layer <= 1'b1;
          end else begin
            n <= n + 1'b1;
          end
        end
        S_ARGMAX: begin
          if (am_take) begin
            best_val <= result[out_idx];
            best_idx <= out_idx;
          end
          n <= n_last ? '0 : n + 1'b1;
          if (n_last) begin
            cat_valid <= 1'b1;
            category  <= am_take ? out_idx : best_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer in a small configuration, with behavioural RAMs, MAC and a golden network.
module tb_nn_layer_sequencer;
  localparam int LANES = 4, DW = 8, N_IN = 8, N_HID = 4, N_OUT = 2;
  localparam int AW = 16, HID_BASE = 16, MAC_LAT = 2;
  localparam int C0 = 2, C1 = 1, CAT_W = 1, W = AW + 2, MEM = 64;
  // LOAD_IN + per hidden neuron (LOAD_W,MAC,BIAS,WAIT,WB) + per output neuron + ARGMAX + DONE
  localparam int EXP_CYCLES = 2 + N_HID * (3 + 2 + 1 + 2 + 1) + N_OUT * (2 + 1 + 1 + 2 + 1) + 2 + 1;

  logic clk = 1'b0;
  logic reset, start, ld_valid;
  logic ld_ready, act_en, act_we, act_wsel, wgt_en, wgt_we;
  logic [AW-1:0] act_addr, wgt_addr;
  logic mac_clear, mac_acc, mac_bias, busy, done, cat_valid;
  logic signed [DW-1:0] mac_result;
  logic [CAT_W-1:0] category;

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .LANES(LANES), .DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT),
    .AW(AW), .HID_BASE(HID_BASE), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .act_en(act_en), .act_we(act_we), .act_wsel(act_wsel), .act_addr(act_addr),
    .wgt_en(wgt_en), .wgt_we(wgt_we), .wgt_addr(wgt_addr),
    .mac_clear(mac_clear), .mac_acc(mac_acc), .mac_bias(mac_bias), .mac_result(mac_result),
    .busy(busy), .done(done), .cat_valid(cat_valid), .category(category)
  );

  logic [63:0] out_vec;
  assign out_vec = 64'({ld_ready, act_en, act_we, act_wsel, act_addr, wgt_en, wgt_we, wgt_addr,
                        mac_clear, mac_acc, mac_bias, busy, done, cat_valid, category});

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Network parameters and environment state
  logic signed [DW-1:0] x_in [N_IN];
  logic signed [DW-1:0] w0 [N_HID][N_IN+1];
  logic signed [DW-1:0] w1 [N_OUT][N_HID+1];
  logic signed [DW-1:0] act_mem [MEM];
  logic signed [DW-1:0] wgt_mem [MEM];
  logic signed [DW-1:0] rd_a [LANES];
  logic signed [DW-1:0] rd_w [LANES];
  logic [LANES*DW-1:0]  beat_q[$];
  logic [W-1:0]         exp_q[$];
  logic [CAT_W-1:0]     cat_q[$];
  logic [W-1:0]         got_w;
  logic signed [DW-1:0] pend_val;
  int  acc, pend_cnt, wb_seen, done_cyc;
  bit  hold, done_seen;

  function automatic logic signed [DW-1:0] sat(input int v);
    int hi, lo;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    if (v > hi) return DW'(hi);
    if (v < lo) return DW'(lo);
    return v[DW-1:0];
  endfunction

  function automatic logic [CAT_W-1:0] golden_cat();
    logic signed [DW-1:0] h [N_HID];
    logic signed [DW-1:0] y;
    int s, best, best_i;
    best = 0;
    best_i = 0;
    for (int k = 0; k < N_HID; k++) begin
      s = w0[k][N_IN];
      for (int i = 0; i < N_IN; i++) s += x_in[i] * w0[k][i];
      h[k] = sat(s);
    end
    for (int o = 0; o < N_OUT; o++) begin
      s = w1[o][N_HID];
      for (int j = 0; j < N_HID; j++) s += h[j] * w1[o][j];
      y = sat(s);
      if (o == 0 || int'(y) > best) begin
        best = y;
        best_i = o;
      end
    end
    return CAT_W'(best_i);
  endfunction

  task automatic random_net();
    for (int i = 0; i < N_IN; i++) x_in[i] = DW'(int'($urandom_range(0, 8)) - 4);
    for (int k = 0; k < N_HID; k++)
      for (int i = 0; i <= N_IN; i++) w0[k][i] = DW'(int'($urandom_range(0, 8)) - 4);
    for (int o = 0; o < N_OUT; o++)
      for (int j = 0; j <= N_HID; j++) w1[o][j] = DW'(int'($urandom_range(0, 6)) - 3);
  endtask

  // Zero output-layer weights so each output neuron reduces to its bias.
  task automatic set_out_bias(input int b0, input int b1);
    for (int o = 0; o < N_OUT; o++)
      for (int j = 0; j < N_HID; j++) w1[o][j] = '0;
    w1[0][N_HID] = DW'(b0);
    w1[1][N_HID] = DW'(b1);
  endtask

  // Queue the load beats, the RAM writes they must cause, and the expected category.
  task automatic load_job();
    logic [LANES*DW-1:0] wd;
    for (int k = 0; k < C0; k++) begin
      wd = '0;
      for (int l = 0; l < LANES; l++)
        if (k * LANES + l < N_IN) wd[l*DW +: DW] = x_in[k*LANES+l];
      beat_q.push_back(wd);
      exp_q.push_back({2'b10, AW'(k * LANES)});
    end
    for (int n = 0; n < N_HID; n++) begin
      for (int k = 0; k <= C0; k++) begin
        wd = '0;
        if (k < C0) begin
          for (int l = 0; l < LANES; l++)
            if (k * LANES + l < N_IN) wd[l*DW +: DW] = w0[n][k*LANES+l];
        end else begin
          wd[DW-1:0] = w0[n][N_IN];
        end
        beat_q.push_back(wd);
        exp_q.push_back({2'b00, AW'(k * LANES)});
      end
      exp_q.push_back({2'b11, AW'(HID_BASE + n)});
    end
    for (int o = 0; o < N_OUT; o++) begin
      for (int k = 0; k <= C1; k++) begin
        wd = '0;
        if (k < C1) begin
          for (int l = 0; l < LANES; l++)
            if (k * LANES + l < N_HID) wd[l*DW +: DW] = w1[o][k*LANES+l];
        end else begin
          wd[DW-1:0] = w1[o][N_HID];
        end
        beat_q.push_back(wd);
        exp_q.push_back({2'b00, AW'(k * LANES)});
      end
    end
    cat_q.push_back(golden_cat());
  endtask

  // Environment: RAMs with one-cycle read latency and a MAC with MAC_LAT result latency.
  always @(negedge clk) begin
    if (reset) begin
      pend_cnt = 0;
      hold = 1'b0;
      acc = 0;
    end else begin
      if (mac_clear) acc = 0;
      if (mac_acc) for (int l = 0; l < LANES; l++) acc += rd_a[l] * rd_w[l];
      if (mac_bias) begin
        pend_val = sat(acc + rd_w[0]);
        pend_cnt = MAC_LAT;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mac_result = pend_val;
          hold = 1'b1;
        end
      end else if (hold) begin
        mac_result = ~pend_val;
        hold = 1'b0;
      end

      if ((act_en && act_we) || (wgt_en && wgt_we)) begin
        got_w = act_we ? {1'b1, act_wsel, act_addr} : {2'b00, wgt_addr};
        check("wr_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("wr_seq", got_w, exp_q.pop_front());
      end
      if (act_en && act_we && act_wsel) begin
        if (act_addr < MEM) act_mem[act_addr] = mac_result;
        wb_seen++;
      end else if (act_en && act_we && beat_q.size() != 0) begin
        for (int l = 0; l < LANES; l++)
          if (act_addr + l < MEM) act_mem[act_addr+l] = beat_q[0][l*DW +: DW];
      end
      if (wgt_en && wgt_we && beat_q.size() != 0)
        for (int l = 0; l < LANES; l++)
          if (wgt_addr + l < MEM) wgt_mem[wgt_addr+l] = beat_q[0][l*DW +: DW];

      for (int l = 0; l < LANES; l++) begin
        rd_a[l] = (act_en && !act_we && act_addr + l < MEM) ? act_mem[act_addr+l] : '0;
        rd_w[l] = (wgt_en && !wgt_we && wgt_addr + l < MEM) ? wgt_mem[wgt_addr+l] : '0;
      end

      if (ld_valid && ld_ready) begin
        check("accept_writes", 64'(act_we | wgt_we), 1);
        check("beat_available", 64'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) void'(beat_q.pop_front());
      end

      if (done) begin
        check("cat_valid_at_done", cat_valid, 1);
        check("cat_expected", 64'(cat_q.size() != 0), 1);
        if (cat_q.size() != 0) check("category", category, cat_q.pop_front());
        done_seen = 1'b1;
        done_cyc = cyc;
      end
    end
  end

  // One inference; optionally aborted by reset during the MAC of hidden neuron 2.
  task automatic run_job(input bit gaps, input int exp_cyc, input bit abort_mid);
    int t0, guard;
    load_job();
    done_seen = 1'b0;
    wb_seen = 0;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cat_valid_cleared", cat_valid, 0);
    guard = 0;
    while (!done_seen && guard < 3000) begin
      if (abort_mid && wb_seen == 2 && act_en && !act_we) begin
        reset = 1'b1;
        #1;
        check("abort_outputs", out_vec, 0);
        @(posedge clk); #1;
        check("abort_next_cycle", out_vec, 0);
        reset = 1'b0;
        ld_valid = 1'b0;
        beat_q.delete();
        exp_q.delete();
        cat_q.delete();
        return;
      end
      ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (guard == 5);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    ld_valid = 1'b0;
    check("done_in_budget", 64'(done_seen), 1);
    if (exp_cyc >= 0) check("start_to_done_cycles", 64'(done_cyc - t0), 64'(exp_cyc));
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("writes_drained", 64'(exp_q.size()), 0);
    check("beats_drained", 64'(beat_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    check("cat_valid_held", cat_valid, 1);
    check("ld_ready_idle", ld_ready, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ld_valid = 1'b0;
    mac_result = '0;
    for (int i = 0; i < MEM; i++) begin
      act_mem[i] = '0;
      wgt_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", out_vec, 0);

    random_net();
    run_job(1'b0, EXP_CYCLES, 1'b0);

    random_net();
    set_out_bias(-5, 3);
    run_job(1'b1, -1, 1'b0);
    check("cat_m5_p3", category, 1);

    random_net();
    set_out_bias(7, 7);
    run_job(1'b0, EXP_CYCLES, 1'b0);
    check("cat_tie_low", category, 0);

    random_net();
    set_out_bias(-128, -127);
    run_job(1'b1, -1, 1'b0);
    check("cat_m128_m127", category, 1);

    random_net();
    run_job(1'b0, -1, 1'b1);
    check("wb_before_abort", 64'(wb_seen), 2);

    random_net();
    set_out_bias(2, -1);
    run_job(1'b0, EXP_CYCLES, 1'b0);
    check("cat_after_abort", category, 0);

    random_net();
    run_job(1'b1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
